// File: rtl/rv_core_pkg.sv
// Shared RV32 core definitions: default data width, register index type and
// well-known register numbers.
package rv_core_pkg;
  localparam int RV_XLEN  = 32;
  localparam int RV_NREGS = 32;

  typedef logic [$clog2(RV_NREGS)-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
  localparam reg_idx_t REG_SP   = reg_idx_t'(2);
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins a tie.
// Register 0 is never marked busy.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             wr0_en,
  input  logic [AW-1:0]    wr0_addr,
  input  logic             wr1_en,
  input  logic [AW-1:0]    wr1_addr,
  output logic [NREGS-1:0] busy_vec
);
  logic [NREGS-1:0] busy_q, set_v, clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_en) set_v[iss_addr] = 1'b1;
    if (wr0_en) clr_v[wr0_addr] = 1'b1;
    if (wr1_en) clr_v[wr1_addr] = 1'b1;
    set_v[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= set_v | (busy_q & ~clr_v);
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file (NUM_RD reads, 2 writes) with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp
  import rv_core_pkg::*;
#(
  parameter int             XLEN    = RV_XLEN,
  parameter int             NREGS   = RV_NREGS,
  parameter int             NUM_RD  = 2,
  parameter int             SP_IDX  = int'(REG_SP),
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [$clog2(NREGS)-1:0] wr0_addr,
  input  logic [XLEN-1:0]          wr0_data,
  input  logic                     wr1_en,
  input  logic [$clog2(NREGS)-1:0] wr1_addr,
  input  logic [XLEN-1:0]          wr1_data,
  input  logic                     iss_en,
  input  logic [$clog2(NREGS)-1:0] iss_addr,
  output logic [NREGS-1:0]         busy_vec
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREGS];

  // wr1 is applied last so a load beats an ALU result to the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= (r == SP_IDX) ? SP_INIT : '0;
    end else begin
      if (wr0_en && wr0_addr != ZERO) regs[wr0_addr] <= wr0_data;
      if (wr1_en && wr1_addr != ZERO) regs[wr1_addr] <= wr1_data;
    end
  end

  reg_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .busy_vec (busy_vec)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] arr;
    assign a   = rd_addr[i*AW +: AW];
    assign arr = (a == ZERO) ? '0 : regs[a];
`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1, iss_hit;
    assign hit1    = wr1_en && wr1_addr == a && a != ZERO;
    assign hit0    = wr0_en && wr0_addr == a && a != ZERO;
    assign iss_hit = iss_en && iss_addr == a;
    assign rd_data[i*XLEN +: XLEN] = hit1 ? wr1_data : hit0 ? wr0_data : arr;
    // a forwarded value is not busy, unless a new producer issues to it this cycle
    assign rd_busy[i] = busy_vec[a] & ~((hit0 | hit1) & ~iss_hit);
`else
    assign rd_data[i*XLEN +: XLEN] = arr;
    assign rd_busy[i] = busy_vec[a];
`endif
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised + directed bench for reg_file_mp against an array/scoreboard model.
module tb_reg_file_mp;
  localparam int XLEN = 32, NREGS = 32, NUM_RD = 4, AW = 5;
  localparam logic [31:0] SPV = 32'h0000_1000;

  logic clk = 1'b0, rst;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic wr0_en, wr1_en, iss_en;
  logic [AW-1:0] wr0_addr, wr1_addr, iss_addr;
  logic [XLEN-1:0] wr0_data, wr1_data;
  logic [NREGS-1:0] busy_vec;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .SP_IDX(2), .SP_INIT(SPV)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] m_reg [NREGS];
  bit          m_busy [NREGS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [31:0] exp_rd(input int a);
    if (a == 0) return 32'h0;
    if (BYP && wr1_en && int'(wr1_addr) == a) return wr1_data;
    if (BYP && wr0_en && int'(wr0_addr) == a) return wr0_data;
    return m_reg[a];
  endfunction

  function automatic bit exp_rbusy(input int a);
    bit fwd;
    fwd = BYP && a != 0 && ((wr1_en && int'(wr1_addr) == a) || (wr0_en && int'(wr0_addr) == a));
    if (fwd && !(iss_en && int'(iss_addr) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic set_rd(input int i, input int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0; wr0_data = '0; wr1_data = '0;
  endtask

  // compare every output with the model, clock once, then advance the model
  task automatic step();
    logic [NREGS-1:0] bv;
    #1;
    for (int i = 0; i < NUM_RD; i++) begin
      chk($sformatf("rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]), 64'(exp_rd(int'(rd_addr[i*AW +: AW]))));
      chk($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(exp_rbusy(int'(rd_addr[i*AW +: AW]))));
    end
    for (int r = 0; r < NREGS; r++) bv[r] = m_busy[r];
    chk("busy_vec", 64'(busy_vec), 64'(bv));
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin m_reg[r] = (r == 2) ? SPV : 32'h0; m_busy[r] = 1'b0; end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        bit wr = (wr0_en && int'(wr0_addr) == r) || (wr1_en && int'(wr1_addr) == r);
        if (iss_en && int'(iss_addr) == r) m_busy[r] = 1'b1;
        else if (wr) m_busy[r] = 1'b0;
      end
      if (wr0_en && wr0_addr != 0) m_reg[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 0) m_reg[wr1_addr] = wr1_data;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rd_addr = '0;
    for (int r = 0; r < NREGS; r++) begin m_reg[r] = 'x; m_busy[r] = 1'b0; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    for (int r = 0; r < NREGS; r++) m_reg[r] = (r == 2) ? SPV : 32'h0;
    @(negedge clk);
    idle();
    // reset values
    set_rd(0, 2); set_rd(1, 5); set_rd(2, 0); set_rd(3, 31);
    #1;
    chk("rst_sp", 64'(rd_data[31:0]), 64'(SPV));
    chk("rst_x5", 64'(rd_data[63:32]), 64'h0);
    chk("rst_busy", 64'(busy_vec), 64'h0);
    step();
    // x0 hardwired
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hDEAD_BEEF; iss_en = 1'b1; iss_addr = 5'd0;
    set_rd(0, 0);
    step(); idle(); #1;
    chk("x0_read", 64'(rd_data[31:0]), 64'h0);
    chk("x0_busy", 64'(busy_vec[0]), 64'h0);
    // dual write, load wins, busy cleared
    iss_en = 1'b1; iss_addr = 5'd7; step(); idle();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
    set_rd(1, 7);
    step(); idle(); #1;
    chk("x7_load_wins", 64'(rd_data[63:32]), 64'h22);
    chk("x7_busy_clr", 64'(busy_vec[7]), 64'h0);
    // issue beats writeback
    iss_en = 1'b1; iss_addr = 5'd9; step(); idle();
    set_rd(2, 9); #1;
    chk("x9_busy", 64'(busy_vec[9]), 64'h1);
    chk("x9_rd_busy", 64'(rd_busy[2]), 64'h1);
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h5; iss_en = 1'b1; iss_addr = 5'd9;
    step(); idle(); #1;
    chk("x9_still_busy", 64'(busy_vec[9]), 64'h1);
    chk("x9_data", 64'(rd_data[95:64]), 64'h5);
    // same-cycle read of a write
    set_rd(3, 3); wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hAB; #1;
    chk("x3_same_cycle", 64'(rd_data[127:96]), BYP ? 64'hAB : 64'h0);
    chk("x3_same_busy", 64'(rd_busy[3]), 64'h0);
    step(); idle(); #1;
    chk("x3_next_cycle", 64'(rd_data[127:96]), 64'hAB);
    // mid-run reset clears busy and data
    iss_en = 1'b1; iss_addr = 5'd4; step();
    iss_addr = 5'd6; step(); idle();
    rst = 1'b1; wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h77; step(); idle();
    set_rd(0, 2); set_rd(1, 4); set_rd(2, 6); set_rd(3, 7); #1;
    chk("rst2_busy", 64'(busy_vec), 64'h0);
    chk("rst2_sp", 64'(rd_data[31:0]), 64'(SPV));
    chk("rst2_x4", 64'(rd_data[63:32]), 64'h0);
    chk("rst2_x7", 64'(rd_data[127:96]), 64'h0);
    // random traffic, addresses biased to a small window to force collisions
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      wr0_en   = $urandom_range(0, 1) == 1;
      wr1_en   = $urandom_range(0, 2) == 0;
      iss_en   = $urandom_range(0, 1) == 1;
      wr0_addr = AW'($urandom_range(0, 7));
      wr1_addr = AW'($urandom_range(0, 7));
      iss_addr = AW'($urandom_range(0, 7));
      wr0_data = $urandom;
      wr1_data = $urandom;
      for (int i = 0; i < NUM_RD; i++)
        set_rd(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
